// File: rtl/fifo_serializer_if.sv
// Bus bundle for fifo_serializer: show-ahead fifo read side plus the narrow valid/ready beat stream.
interface fifo_serializer_if #(
    parameter int WIDTH     = 32,
    parameter int OUT_WIDTH = 8,
    parameter int CNT_WIDTH = 16
);
    logic                 enable_i;
    logic [WIDTH-1:0]     fifo_dout_i;
    logic                 fifo_empty_i;
    logic                 fifo_re_o;
    logic [OUT_WIDTH-1:0] data_o;
    logic                 valid_o;
    logic                 ready_i;
    logic                 last_o;
    logic                 busy_o;
    logic [CNT_WIDTH-1:0] words_o;

    modport master (
        input  enable_i, fifo_dout_i, fifo_empty_i, ready_i,
        output fifo_re_o, data_o, valid_o, last_o, busy_o, words_o
    );

    modport slave (
        output enable_i, fifo_dout_i, fifo_empty_i, ready_i,
        input  fifo_re_o, data_o, valid_o, last_o, busy_o, words_o
    );
endinterface

// File: rtl/fifo_serializer.sv
// Pops WIDTH-bit words from a show-ahead fifo and emits them LSB slice first as
// OUT_WIDTH-bit valid/ready beats, reloading on the last beat so words stream without bubbles.
module fifo_serializer #(
    parameter int WIDTH     = 32,
    parameter int OUT_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    fifo_serializer_if.master  bus
);
    localparam int RATIO  = WIDTH / OUT_WIDTH;
    localparam int BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     shift_q;
    logic [WIDTH-1:0]     shift_nxt;
    logic [BEAT_W-1:0]    beat_q;
    logic [CNT_WIDTH-1:0] words_q;

    logic valid;
    logic last;
    logic xfer;
    logic load;

    assign valid = (state_q == SEND);
    assign last  = valid && (beat_q == LAST_BEAT);
    assign xfer  = valid && bus.ready_i;
    // rst_i gates the pop so a word is never taken from the fifo while being discarded
    assign load  = bus.enable_i && !bus.fifo_empty_i && !rst_i &&
                   ((state_q == IDLE) || (xfer && last));

    generate
        if (RATIO > 1) begin : g_shift
            assign shift_nxt = {{OUT_WIDTH{1'b0}}, shift_q[WIDTH-1:OUT_WIDTH]};
        end else begin : g_noshift
            assign shift_nxt = shift_q;
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            shift_q <= '0;
            beat_q  <= '0;
            words_q <= '0;
        end else begin
            if (load) begin
                shift_q <= bus.fifo_dout_i;
                beat_q  <= '0;
                state_q <= SEND;
            end else if (xfer && last) begin
                state_q <= IDLE;
            end else if (xfer) begin
                shift_q <= shift_nxt;
                beat_q  <= beat_q + BEAT_W'(1);
            end
            if (xfer && last) begin
                words_q <= words_q + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.fifo_re_o = load;
    assign bus.data_o    = shift_q[OUT_WIDTH-1:0];
    assign bus.valid_o   = valid;
    assign bus.busy_o    = valid;
    assign bus.last_o    = last;
    assign bus.words_o   = words_q;
endmodule

// File: tb/tb_fifo_serializer.sv
// Scoreboard bench for fifo_serializer: a fifo model feeds the DUT, popped words are split into
// expected beats, and a monitor checks handshake, data, last, pop strobe and word count each cycle.
module tb_fifo_serializer;
    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_serializer_if #(.WIDTH(32), .OUT_WIDTH(8), .CNT_WIDTH(16)) bus ();
    fifo_serializer_if #(.WIDTH(8),  .OUT_WIDTH(8), .CNT_WIDTH(4))  b2 ();

    fifo_serializer #(.WIDTH(32), .OUT_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus.master)
    );
    fifo_serializer #(.WIDTH(8), .OUT_WIDTH(8), .CNT_WIDTH(4)) dut2 (
        .clk_i(clk), .rst_i(rst), .bus(b2.master)
    );

    int          checks   = 0;
    int          failures = 0;
    bit          mon_en   = 1'b0;
    logic [31:0] fq[$];
    beat_t       exp_q[$];
    logic [15:0] exp_words = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: compares the DUT against the expected-beat queue once inputs have settled.
    always @(negedge clk) begin
        logic load_m;
        #1;
        if (mon_en) begin
            load_m = bus.enable_i && !bus.fifo_empty_i &&
                     ((exp_q.size() == 0) || (bus.ready_i && exp_q[0].last));
            chk("fifo_re", 64'(bus.fifo_re_o), 64'(load_m));
            chk("valid",   64'(bus.valid_o),   64'(exp_q.size() != 0));
            chk("busy",    64'(bus.busy_o),    64'(exp_q.size() != 0));
            chk("words",   64'(bus.words_o),   64'(exp_words));
            if (exp_q.size() != 0) begin
                chk("data", 64'(bus.data_o), 64'(exp_q[0].data));
                chk("last", 64'(bus.last_o), 64'(exp_q[0].last));
                if (bus.ready_i) begin
                    if (exp_q[0].last) exp_words = exp_words + 16'd1;
                    void'(exp_q.pop_front());
                end
            end else begin
                chk("last_idle", 64'(bus.last_o), 64'd0);
            end
        end
    end

    // mode: 0 = low, 1 = high, 2 = random
    task automatic cycle(input int rmode, input int emode);
        logic [31:0] w;
        @(negedge clk);
        bus.ready_i      = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
        bus.enable_i     = (emode == 2) ? ($urandom_range(0, 3) != 0) : (emode == 1);
        bus.fifo_empty_i = (fq.size() == 0);
        bus.fifo_dout_i  = (fq.size() != 0) ? fq[0] : 32'h0;
        #2;
        if (bus.fifo_re_o && fq.size() != 0) begin
            w = fq.pop_front();
            for (int k = 0; k < 4; k++) exp_q.push_back('{data: w[8*k +: 8], last: (k == 3)});
        end
    endtask

    initial begin
        int idx, next_beat, prev;
        bit seen15, wrapped;

        bus.ready_i = 1'b0; bus.enable_i = 1'b0; bus.fifo_empty_i = 1'b1; bus.fifo_dout_i = '0;
        b2.ready_i  = 1'b1; b2.enable_i  = 1'b0; b2.fifo_empty_i  = 1'b1; b2.fifo_dout_i  = '0;

        #12;
        chk("rst_valid", 64'(bus.valid_o),   64'd0);
        chk("rst_busy",  64'(bus.busy_o),    64'd0);
        chk("rst_last",  64'(bus.last_o),    64'd0);
        chk("rst_data",  64'(bus.data_o),    64'd0);
        chk("rst_words", 64'(bus.words_o),   64'd0);
        chk("rst_re",    64'(bus.fifo_re_o), 64'd0);
        #11;
        rst    = 1'b0;
        mon_en = 1'b1;

        // single word
        fq.push_back(32'hA1B2C3D4);
        repeat (8) cycle(1, 1);
        chk("single_words", 64'(bus.words_o), 64'd1);

        // back-to-back words
        fq.push_back(32'h03020100);
        fq.push_back(32'h07060504);
        repeat (12) cycle(1, 1);
        chk("b2b_words", 64'(bus.words_o), 64'd3);

        // backpressure on beat 1
        fq.push_back(32'hA1B2C3D4);
        repeat (2) cycle(1, 1);
        repeat (3) cycle(0, 1);
        repeat (6) cycle(1, 1);

        // enable drop mid-word with two words queued, then empty fifo
        fq.push_back(32'h11223344);
        fq.push_back(32'h55667788);
        repeat (2) cycle(1, 1);
        repeat (8) cycle(1, 0);
        chk("en_hold_fifo", 64'(fq.size()), 64'd1);
        repeat (8) cycle(1, 1);
        repeat (5) cycle(1, 1);
        chk("empty_drained", 64'(exp_q.size()), 64'd0);

        // asynchronous reset mid-word
        fq.push_back(32'hDEADBEEF);
        fq.push_back(32'hCAFEF00D);
        repeat (3) cycle(1, 1);
        #1;
        rst    = 1'b1;
        mon_en = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.valid_o),   64'd0);
        chk("arst_data",  64'(bus.data_o),    64'd0);
        chk("arst_words", 64'(bus.words_o),   64'd0);
        chk("arst_re",    64'(bus.fifo_re_o), 64'd0);
        exp_q.delete();
        exp_words = '0;
        repeat (2) @(posedge clk);
        #3;
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (8) cycle(1, 1);
        chk("arst_next_word", 64'(bus.words_o), 64'd1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0 && fq.size() < 4) fq.push_back($urandom);
            cycle(2, 2);
        end
        repeat (60) cycle(1, 1);
        chk("random_drained", 64'(exp_q.size() + fq.size()), 64'd0);

        // counter wrap with RATIO=1, CNT_WIDTH=4
        idx = 0; next_beat = 0; prev = 0; seen15 = 1'b0; wrapped = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            b2.enable_i     = 1'b1;
            b2.fifo_empty_i = (idx >= 17);
            b2.fifo_dout_i  = 8'(8'h40 + idx);
            #1;
            if (b2.valid_o) begin
                chk("wrap_data", 64'(b2.data_o), 64'(8'(8'h40 + next_beat)));
                chk("wrap_last", 64'(b2.last_o), 64'd1);
                next_beat++;
            end
            if (b2.words_o == 4'd15) seen15 = 1'b1;
            if (prev == 15 && b2.words_o == 4'd0) wrapped = 1'b1;
            prev = int'(b2.words_o);
            if (b2.fifo_re_o) idx++;
        end
        chk("wrap_seen15",  64'(seen15),      64'd1);
        chk("wrap_wrapped", 64'(wrapped),     64'd1);
        chk("wrap_final",   64'(b2.words_o),  64'd1);
        chk("wrap_beats",   64'(next_beat),   64'd17);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_serializer.md
# fifo_serializer

Read-side companion for the team's show-ahead `fifo`, which presents its head word on `dout_o` whenever it is not empty. This block pops WIDTH-bit words from the fifo and serializes each one, LSB slice first, into OUT_WIDTH-bit beats on a valid/ready output stream. It sits between a wide producer-side fifo and a narrow consumer such as a UART TX or byte bus. Sustained throughput is one beat per cycle, with no bubble between words.

## Interface
- WIDTH, 32, fifo word width; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 8, output beat width.
- CNT_WIDTH, 16, width of the completed-word counter.
- Derived: RATIO = WIDTH/OUT_WIDTH; beat counter width = max(1, $clog2(RATIO)).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- Clock and reset: one clock; reset is asynchronous and active-high.
- enable_i  in  1  permits popping new words from the fifo.
- fifo_dout_i  in  WIDTH  head word of the fifo (show-ahead).
- fifo_empty_i  in  1  fifo `E_o`.
- fifo_re_o  out  1  pop strobe to fifo `re_i`; combinational.
- data_o  out  OUT_WIDTH  current beat.
- valid_o  out  1  beat valid.
- ready_i  in  1  consumer accepts beat.
- last_o  out  1  current beat is the final slice of its word.
- busy_o  out  1  a word is loaded (state SEND).
- words_o  out  CNT_WIDTH  count of fully transmitted words; wraps modulo 2^CNT_WIDTH.

## Operation
- Registers:
  - state_q ∈ {IDLE, SEND}
  - shift_q[WIDTH]
  - beat_q (beat counter)
  - words_q[CNT_WIDTH]
- Outputs:
  - data_o = shift_q[OUT_WIDTH-1:0]; valid_o = busy_o = (state_q==SEND).
  - last_o = valid_o && beat_q==RATIO-1.
  - words_o = words_q.
- Handshake: a beat transfers when valid_o && ready_i.
- Load condition: load = enable_i && !fifo_empty_i && !rst_i && (state_q==IDLE || (transfer && last_o)). fifo_re_o = load.
- IDLE:
  - On load: shift_q<=fifo_dout_i, beat_q<=0, go to SEND.
  - Otherwise hold.
- SEND, transfer with beat_q<RATIO-1: shift_q <= shift_q >> OUT_WIDTH, beat_q++.
- SEND, transfer with last_o:
  - words_q++.
  - If load: reload shift_q from fifo_dout_i, beat_q<=0, stay in SEND.
  - Else go to IDLE.
- SEND without a transfer: all registers hold. data_o and last_o must stay stable while valid_o && !ready_i.
- enable_i low mid-word: the current word completes in full. No new pop occurs until enable_i is high.
- fifo_empty_i is never sampled in SEND except at a last-beat transfer. fifo_re_o is never asserted while fifo_empty_i=1.
- RATIO==1: every beat is last; each transfer pops the next word.
- Reset (asynchronous, any time, including mid-word): state_q=IDLE, shift_q=0, beat_q=0, words_q=0. The partially sent word is discarded; the fifo is not popped again for it.

## Timing
- Reset values: valid_o=0, busy_o=0, last_o=0, data_o=0, words_o=0, fifo_re_o=0.
- Pop-to-valid latency: fifo_re_o is high in cycle N; valid_o is high from cycle N+1 with slice 0 of that word.
- Words per word-time: with ready_i held high, a word occupies exactly RATIO consecutive valid cycles.
- Back-to-back: the next word's slice 0 appears in the cycle after the previous last beat, with no idle cycle, provided the fifo is non-empty and enable_i=1 at the last-beat transfer.
- Counter update: words_o increments in the cycle after the last-beat transfer.
- Fifo interaction: the pop and the fifo's internal shift happen on the same edge. fifo_dout_i is sampled in the same cycle fifo_re_o is high.

## Test plan
- **Reset / single word.** Reset, then push 0xA1B2C3D4 with ready_i=1, enable_i=1. Expect fifo_re_o for one cycle, then data_o = D4, C3, B2, A1 on 4 consecutive cycles. last_o is high only on A1; words_o=1; busy_o is low after.
- **Back-to-back words.** Push 0x03020100 and 0x07060504. Expect 8 contiguous valid beats 00..07, last_o on 03 and 07, and fifo_re_o pulses exactly 4 cycles apart.
- **Backpressure.** Drop ready_i for 3 cycles on beat 1 (C3). Expect data_o=C3 and valid_o=1 held, no shift, fifo_re_o=0; the stream resumes at B2.
- **Enable drop and empty.** Deassert enable_i mid-word with 2 words queued. Expect the current word to finish, then valid_o=0 and fifo_re_o=0 until enable_i returns. With the fifo empty and enable_i=1, expect fifo_re_o never to assert.
- **Reset mid-word.** Assert rst_i asynchronously after beat 1. Expect valid_o=0, words_o=0, and data_o=0 immediately, not waiting for a clock edge. After release, the next fifo word starts from slice 0.
- **Wrap.** Use CNT_WIDTH=4, RATIO=1, and send 17 words. Expect words_o to reach 15, wrap to 0, and end at 1.
